pattern_sequencer: RTL

Parametrised successor to the team's fixed 4-output demo counter. It is a WIDTH-bit sequencer driven by a programmable prescaler, with four run-time selectable sequence modes (binary up, binary down, Johnson ring, maximal-length LFSR), a parallel load and a wrap pulse. It sits directly under the pin-level top-level shell. CLK and RST come from io_in[0] and io_in[1], control bits come from the remaining io_in pins, and O/TICK drive io_out.

---
 rtl/pattern_seq_pkg.sv | 33 +++
 rtl/pattern_sequencer_prescaler.sv | 38 +++
 rtl/pattern_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared types and constants for pattern_sequencer.
// Holds the mode enum, the LFSR tap table and the legal parameter bounds.
package pattern_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_LFSR    = 2'b11
    } mode_e;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 7;
    localparam int PRESCALE_MIN = 0;
    localparam int PRESCALE_MAX = 8;

    // Fibonacci tap masks of primitive polynomials, bit i = O[i].
    function automatic logic [WIDTH_MAX-1:0] lfsr_taps(input int width);
        logic [WIDTH_MAX-1:0] m;
        m = '0;
        case (width)
            2: m = 7'b000_0011;
            3: m = 7'b000_0110;
            4: m = 7'b000_1100;
            5: m = 7'b001_0100;
            6: m = 7'b011_0000;
            7: m = 7'b110_0000;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pattern_sequencer_prescaler.sv
// step_prescaler: divides enabled cycles by 2^PRESCALE_BITS into STEP.
// Ports: CLK, RST (sync high), EN count enable, CLR restart -> STEP.
module step_prescaler
    import pattern_seq_pkg::*;
#(
    parameter int PRESCALE_BITS = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic STEP
);

    // A zero-width divider is kept as a 1-bit register pinned at 0,
    // so STEP collapses to EN without a separate code path.
    localparam int CW = (PRESCALE_BITS == 0) ? 1 : PRESCALE_BITS;
    localparam logic [CW-1:0] CMAX = CW'((1 << PRESCALE_BITS) - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CMAX);
    assign STEP   = EN && w_last;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_cnt <= '0;
        end else if (EN) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: prescaled WIDTH-bit up/down/Johnson/LFSR sequencer.
// Ports: CLK, RST, EN, MODE, LOAD, DIN in; O state and TICK wrap pulse out.
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int PRESCALE_BITS = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] O,
    output logic             TICK
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("pattern_sequencer: WIDTH out of range");
    end
    if (PRESCALE_BITS < PRESCALE_MIN ||
        PRESCALE_BITS > PRESCALE_MAX) begin : g_bad_pre
        $error("pattern_sequencer: PRESCALE_BITS out of range");
    end

    localparam logic [WIDTH_MAX-1:0] TAPS = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_o;
    logic             r_tick;
    logic             w_step;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_fb;

    assign w_mode = mode_e'(MODE);
    assign w_fb   = ^(r_o & TAPS[WIDTH-1:0]);

    step_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_pre (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .CLR (LOAD),
        .STEP(w_step)
    );

    always_comb begin
        w_next = r_o;
        w_wrap = 1'b0;
        unique case (w_mode)
            MODE_UP: begin
                w_next = r_o + 1'b1;
                w_wrap = &r_o;
            end
            MODE_DOWN: begin
                w_next = r_o - 1'b1;
                w_wrap = (r_o == '0);
            end
            MODE_JOHNSON: begin
                w_next = {r_o[WIDTH-2:0], ~r_o[WIDTH-1]};
                w_wrap = (w_next == '0);
            end
            MODE_LFSR: begin
                // All-zero is the lock-up state; escape silently to 1.
                if (r_o == '0) begin
                    w_next = ONE;
                    w_wrap = 1'b0;
                end else begin
                    w_next = {r_o[WIDTH-2:0], w_fb};
                    w_wrap = (w_next == ONE);
                end
            end
            default: begin
                w_next = r_o;
                w_wrap = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_o    <= '0;
            r_tick <= 1'b0;
        end else if (LOAD) begin
            r_o    <= DIN;
            r_tick <= 1'b0;
        end else if (w_step) begin
            r_o    <= w_next;
            r_tick <= w_wrap;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign O    = r_o;
    assign TICK = r_tick;

endmodule
